// File: rtl/mtl_disp_pkg.sv
// Shared types for the MTL display timing controller: colour modes and the
// colour-bar table (one on/off flag per channel, expanded to full scale by the user).
package mtl_disp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_WHITE = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam int BAR_COUNT = 8;

    // Left-to-right bar order across the active width.
    localparam rgb_t BAR_TABLE [BAR_COUNT] = '{
        '{r: 1'b1, g: 1'b1, b: 1'b1},
        '{r: 1'b1, g: 1'b1, b: 1'b0},
        '{r: 1'b0, g: 1'b1, b: 1'b1},
        '{r: 1'b0, g: 1'b1, b: 1'b0},
        '{r: 1'b1, g: 1'b0, b: 1'b1},
        '{r: 1'b1, g: 1'b0, b: 1'b0},
        '{r: 1'b0, g: 1'b0, b: 1'b1},
        '{r: 1'b0, g: 1'b0, b: 1'b0}
    };

endpackage

// File: rtl/mtl_delay_line.sv
// Fixed-depth shift register; every stage clears to RST_VAL so sync levels
// come out of reset inactive rather than zero.
module mtl_delay_line #(
    parameter int                 WIDTH   = 1,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;
            logic [WIDTH-1:0] stage_q;

            if (gi == 0) begin : g_first
                assign stage_d = d_i;
            end else begin : g_rest
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_q <= RST_VAL;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/mtl_display_timing_ctrl.sv
// MTL panel timing generator: H/V counters, pixel requests with active-area
// coordinates, test patterns, and a delay line aligning sync/DE with colour.
module mtl_display_timing_ctrl
    import mtl_disp_pkg::*;
#(
    parameter int H_LINE  = 1056,
    parameter int V_LINE  = 525,
    parameter int H_BLANK = 46,
    parameter int H_FRONT = 210,
    parameter int V_BLANK = 23,
    parameter int V_FRONT = 22,
    parameter int COLOR_W = 8,
    parameter int REQ_LAT = 1,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int FCNT_W  = 16
) (
    input  logic                       iCLK,
    input  logic                       iRST_n,
    input  logic [3*COLOR_W-1:0]       iColorData,
    input  logic [1:0]                 iMode,
    input  logic                       iBlank,
    output logic                       oReq,
    output logic [$clog2(H_LINE)-1:0]  oReqX,
    output logic [$clog2(V_LINE)-1:0]  oReqY,
    output logic                       oNewFrame,
    output logic                       oEndFrame,
    output logic [FCNT_W-1:0]          oFrameCnt,
    output logic                       oHD,
    output logic                       oVD,
    output logic                       oDE,
    output logic [COLOR_W-1:0]         oLCD_R,
    output logic [COLOR_W-1:0]         oLCD_G,
    output logic [COLOR_W-1:0]         oLCD_B
);

    localparam int XW  = $clog2(H_LINE);
    localparam int YW  = $clog2(V_LINE);
    localparam int BW  = XW + 3;
    localparam int DLW = 7;

    localparam logic [XW-1:0] X_LAST = XW'(H_LINE - 1);
    localparam logic [XW-1:0] X_ACT0 = XW'(H_BLANK);
    localparam logic [XW-1:0] X_ACT1 = XW'(H_LINE - H_FRONT);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINE - 1);
    localparam logic [YW-1:0] Y_ACT0 = YW'(V_BLANK);
    localparam logic [YW-1:0] Y_ACT1 = YW'(V_LINE - V_FRONT);
    localparam logic [BW-1:0] ACT_W  = BW'(H_LINE - H_BLANK - H_FRONT);

    logic [XW-1:0]          x_cnt_q, x_cnt_d;
    logic [YW-1:0]          y_cnt_q, y_cnt_d;
    logic [FCNT_W-1:0]      fcnt_q;
    mode_e                  mode_q;
    logic                   hd_q, vd_q, de_q;
    logic [3*COLOR_W-1:0]   pix_q, pix_d;

    logic                   active;
    logic                   hs_lvl, vs_lvl;
    logic [BW-1:0]          bar_num;
    logic [2:0]             bar_idx;
    logic [DLW-1:0]         dl_in, dl_out;
    logic                   dl_hs, dl_vs, dl_de, dl_blank;
    logic [2:0]             dl_bar;
    rgb_t                   bar_rgb;

    always_comb begin
        x_cnt_d = x_cnt_q + 1'b1;
        y_cnt_d = y_cnt_q;
        if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            y_cnt_d = (y_cnt_q == Y_LAST) ? '0 : y_cnt_q + 1'b1;
        end
    end

    assign active    = (x_cnt_q >= X_ACT0) && (x_cnt_q < X_ACT1) &&
                       (y_cnt_q >= Y_ACT0) && (y_cnt_q < Y_ACT1);
    assign oReq      = active;
    assign oReqX     = x_cnt_q - X_ACT0;
    assign oReqY     = y_cnt_q - Y_ACT0;
    assign oNewFrame = (x_cnt_q == '0) && (y_cnt_q == '0);
    assign oEndFrame = (x_cnt_q == X_ACT1) && (y_cnt_q == Y_ACT1);
    assign oFrameCnt = fcnt_q;

    assign hs_lvl = (x_cnt_q == '0) ? HS_POL : ~HS_POL;
    assign vs_lvl = (y_cnt_q == '0) ? VS_POL : ~VS_POL;

    // Bar index is floor(x*8/W); garbage outside the active area is masked by DE later.
    assign bar_num = {3'b000, oReqX} << 3;
    assign bar_idx = 3'(bar_num / ACT_W);

    assign dl_in = {hs_lvl, vs_lvl, active, iBlank, bar_idx};

    mtl_delay_line #(
        .WIDTH   (DLW),
        .DEPTH   (REQ_LAT),
        .RST_VAL ({~HS_POL, ~VS_POL, 5'b00000})
    ) u_delay (
        .clk_i  (iCLK),
        .rst_ni (iRST_n),
        .d_i    (dl_in),
        .q_o    (dl_out)
    );

    assign {dl_hs, dl_vs, dl_de, dl_blank, dl_bar} = dl_out;
    assign bar_rgb = BAR_TABLE[dl_bar];

    always_comb begin
        pix_d = '0;
        case (mode_q)
            MODE_PASS:  pix_d = iColorData;
            MODE_BARS:  pix_d = {{COLOR_W{bar_rgb.r}}, {COLOR_W{bar_rgb.g}}, {COLOR_W{bar_rgb.b}}};
            MODE_WHITE: pix_d = '1;
            MODE_BLACK: pix_d = '0;
            default:    pix_d = '0;
        endcase
        if (dl_blank || !dl_de) begin
            pix_d = '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            fcnt_q  <= '0;
            mode_q  <= MODE_PASS;
            hd_q    <= ~HS_POL;
            vd_q    <= ~VS_POL;
            de_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            // Mode is only taken at frame start so a frame never mixes patterns.
            if (oNewFrame) begin
                fcnt_q <= fcnt_q + 1'b1;
                mode_q <= mode_e'(iMode);
            end
            hd_q    <= dl_hs;
            vd_q    <= dl_vs;
            de_q    <= dl_de;
            pix_q   <= pix_d;
        end
    end

    assign oHD    = hd_q;
    assign oVD    = vd_q;
    assign oDE    = de_q;
    assign oLCD_R = pix_q[3*COLOR_W-1:2*COLOR_W];
    assign oLCD_G = pix_q[2*COLOR_W-1:COLOR_W];
    assign oLCD_B = pix_q[COLOR_W-1:0];

endmodule

// File: tb/tb_mtl_display_timing_ctrl.sv
// Bench for mtl_display_timing_ctrl on a reduced 40x12 timeline: per-cycle
// reference model from the timing rules, a pattern vector table and a mid-line reset.
module tb_mtl_display_timing_ctrl;

    localparam int HL = 40, VL = 12, HB = 6, HF = 6, VB = 3, VF = 2;
    localparam int CW = 8, RL = 3, FW = 4;
    localparam bit HSP = 1'b1, VSP = 1'b0;
    localparam int XW = $clog2(HL), YW = $clog2(VL);
    localparam int FRAME = HL * VL, LAT = RL + 1, AW = HL - HB - HF, MAXS = 16384;

    logic              iCLK = 1'b0;
    logic              iRST_n = 1'b0;
    logic [3*CW-1:0]   iColorData = '0;
    logic [1:0]        iMode = '0;
    logic              iBlank = 1'b0;
    logic              oReq, oNewFrame, oEndFrame, oHD, oVD, oDE;
    logic [XW-1:0]     oReqX;
    logic [YW-1:0]     oReqY;
    logic [FW-1:0]     oFrameCnt;
    logic [CW-1:0]     oLCD_R, oLCD_G, oLCD_B;

    mtl_display_timing_ctrl #(
        .H_LINE(HL), .V_LINE(VL), .H_BLANK(HB), .H_FRONT(HF), .V_BLANK(VB), .V_FRONT(VF),
        .COLOR_W(CW), .REQ_LAT(RL), .HS_POL(HSP), .VS_POL(VSP), .FCNT_W(FW)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iColorData(iColorData), .iMode(iMode), .iBlank(iBlank),
        .oReq(oReq), .oReqX(oReqX), .oReqY(oReqY), .oNewFrame(oNewFrame), .oEndFrame(oEndFrame),
        .oFrameCnt(oFrameCnt), .oHD(oHD), .oVD(oVD), .oDE(oDE),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B)
    );

    always #5 iCLK = ~iCLK;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int hist_mode  [MAXS];
    int hist_blank [MAXS];
    int hist_rnd   [MAXS];
    int src_req    [MAXS];
    int src_x      [MAXS];
    int src_y      [MAXS];
    logic [23:0] cap [4][32];
    bit cap_en = 1'b0;

    typedef struct {
        int          mode;
        int          x;
        logic [23:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s step=%0d actual=%0h required=%0h", name, n, act, exp);
        end
    endtask

    function automatic int fx(int s); return s % HL; endfunction
    function automatic int fy(int s); return (s / HL) % VL; endfunction
    function automatic bit fact(int s);
        return fx(s) >= HB && fx(s) < HL - HF && fy(s) >= VB && fy(s) < VL - VF;
    endfunction
    function automatic int frame_mode(int s); return hist_mode[(s / FRAME) * FRAME]; endfunction

    function automatic logic [23:0] bar_colour(int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] exp_pix(int m);
        int xr, yr;
        if (!fact(m) || hist_blank[m] != 0) return 24'h0;
        xr = fx(m) - HB;
        yr = fy(m) - VB;
        case (frame_mode(m))
            0: return {8'(xr), 8'(yr), 8'(hist_rnd[m])};
            1: return bar_colour((xr * 8) / AW);
            2: return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_step();
        int m, fc;
        chk("oReq", 32'(oReq), 32'(fact(n)));
        if (fact(n)) begin
            chk("oReqX", 32'(oReqX), 32'(fx(n) - HB));
            chk("oReqY", 32'(oReqY), 32'(fy(n) - VB));
        end
        chk("oNewFrame", 32'(oNewFrame), 32'(fx(n) == 0 && fy(n) == 0));
        chk("oEndFrame", 32'(oEndFrame), 32'(fx(n) == HL - HF && fy(n) == VL - VF));
        fc = (n == 0) ? 0 : ((n - 1) / FRAME + 1) % (1 << FW);
        chk("oFrameCnt", 32'(oFrameCnt), 32'(fc));
        m = n - LAT;
        if (m < 0) begin
            chk("oHD", 32'(oHD), 32'(!HSP));
            chk("oVD", 32'(oVD), 32'(!VSP));
            chk("oDE", 32'(oDE), 32'(0));
            chk("oLCD", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(0));
        end else begin
            chk("oHD", 32'(oHD), 32'((fx(m) == 0) ? HSP : !HSP));
            chk("oVD", 32'(oVD), 32'((fy(m) == 0) ? VSP : !VSP));
            chk("oDE", 32'(oDE), 32'(fact(m)));
            chk("oLCD", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(exp_pix(m)));
            if (cap_en && fact(m) && fy(m) == VB)
                cap[frame_mode(m)][fx(m) - HB] = {oLCD_R, oLCD_G, oLCD_B};
        end
    endtask

    task automatic drive_step(input int mode, input int blank, input int rb);
        hist_mode[n]  = mode;
        hist_blank[n] = blank;
        hist_rnd[n]   = rb;
        iMode  = 2'(mode);
        iBlank = (blank != 0);
        // Pixel source: answers the request made RL cycles ago, noise otherwise.
        if (n >= RL && src_req[n-RL] != 0)
            iColorData = {8'(src_x[n-RL]), 8'(src_y[n-RL]), 8'(hist_rnd[n-RL])};
        else
            iColorData = 24'($urandom());
        src_req[n] = int'(oReq);
        src_x[n]   = int'(oReqX);
        src_y[n]   = int'(oReqY);
    endtask

    task automatic advance();
        @(posedge iCLK);
        #1;
        n++;
    endtask

    task automatic random_step();
        check_step();
        drive_step(int'($urandom_range(0, 3)), int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)));
        advance();
    endtask

    initial begin
        int seg_modes [4] = '{1, 2, 3, 0};

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 32; b++)
                cap[a][b] = 24'h5A5A5A;

        vecs.push_back('{1,  0, 24'hFFFFFF, "bars_x0"});
        vecs.push_back('{1,  3, 24'hFFFFFF, "bars_x3"});
        vecs.push_back('{1,  4, 24'hFFFF00, "bars_x4"});
        vecs.push_back('{1,  7, 24'h00FFFF, "bars_x7"});
        vecs.push_back('{1, 11, 24'h00FF00, "bars_x11"});
        vecs.push_back('{1, 14, 24'hFF00FF, "bars_x14"});
        vecs.push_back('{1, 17, 24'hFF00FF, "bars_x17"});
        vecs.push_back('{1, 18, 24'hFF0000, "bars_x18"});
        vecs.push_back('{1, 21, 24'h0000FF, "bars_x21"});
        vecs.push_back('{1, 24, 24'h0000FF, "bars_x24"});
        vecs.push_back('{1, 25, 24'h000000, "bars_x25"});
        vecs.push_back('{1, 27, 24'h000000, "bars_x27"});
        vecs.push_back('{2,  0, 24'hFFFFFF, "white_x0"});
        vecs.push_back('{2, 27, 24'hFFFFFF, "white_x27"});
        vecs.push_back('{3, 13, 24'h000000, "black_x13"});
        vecs.push_back('{0,  0, 24'h0000A5, "pass_x0"});
        vecs.push_back('{0, 27, 24'h1B00A5, "pass_x27"});

        repeat (3) @(posedge iCLK);
        #1;
        n = 0;
        check_step();
        iRST_n = 1'b1;
        $display("[TB] reset released, random phase");

        repeat (18 * FRAME) random_step();

        cap_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            $display("[TB] directed segment mode=%0d", seg_modes[s]);
            repeat (2 * FRAME) begin
                check_step();
                drive_step(seg_modes[s], 0, 8'hA5);
                advance();
            end
        end
        cap_en = 1'b0;

        foreach (vecs[i]) begin
            chk(vecs[i].name, 32'(cap[vecs[i].mode][vecs[i].x]), 32'(vecs[i].exp));
            $display("[TB] vec %s mode=%0d x=%0d got=%06h want=%06h", vecs[i].name,
                     vecs[i].mode, vecs[i].x, cap[vecs[i].mode][vecs[i].x], vecs[i].exp);
        end

        // Abort mid-line: outputs must return to reset levels without a clock edge.
        for (int k = 0; k < HL && !(fx(n) == 20 && fy(n) == VB + 2); k++) random_step();
        for (int k = 0; k < HL && fx(n) != 20; k++) random_step();
        #2 iRST_n = 1'b0;
        #1;
        chk("rst_oHD", 32'(oHD), 32'(!HSP));
        chk("rst_oVD", 32'(oVD), 32'(!VSP));
        chk("rst_oDE", 32'(oDE), 32'(0));
        chk("rst_oLCD", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(0));
        chk("rst_oReq", 32'(oReq), 32'(0));
        chk("rst_oFrameCnt", 32'(oFrameCnt), 32'(0));
        chk("rst_oNewFrame", 32'(oNewFrame), 32'(1));
        $display("[TB] mid-line reset applied");
        repeat (2) @(posedge iCLK);
        #1;
        n = 0;
        check_step();
        iRST_n = 1'b1;
        $display("[TB] reset released again, random phase");
        repeat (3 * FRAME) random_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
